// File: rtl/ff_pkg.sv
// Shared flip-flop conversion definitions.
// Holds the common reset value and the JK command encodings formed as {j,k}.
// D-based conversion blocks and their benches use these definitions.
package ff_pkg;

    // Value every state bit takes on a synchronous reset.
    localparam logic RST_Q = 1'b0;

    // JK command encodings, formed as {j,k}.
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        RST  = 2'b01,
        SET  = 2'b10,
        TOG  = 2'b11
    } jk_cmd_t;

endpackage

// File: rtl/d_ff.sv
// WIDTH-bit D register with a synchronous, active-high reset to RST_Q.
// This is the only storage in the JK conversion; all JK behaviour is in the
// next-state logic that feeds d.
module d_ff
    import ff_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] state_q;

    // Next state is the D input unchanged; reset is handled in the register.
    always_comb begin
        state_d = d;
    end

    // State register: reset has priority, otherwise capture d.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= {WIDTH{RST_Q}};
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/jk_using_d.sv
// JK flip-flop built from a D register plus next-state logic.
// Each of the WIDTH bits is an independent JK flip-flop sharing clk and rst.
// qb is derived from q combinationally, so q and qb always differ.
module jk_using_d #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] state;

    // JK characteristic equation: set when j and q=0, keep when k=0 and q=1.
    always_comb begin
        d = (j & ~state) | (~k & state);
    end

    d_ff #(
        .WIDTH(WIDTH)
    ) u_d_ff (
        .clk(clk),
        .rst(rst),
        .d  (d),
        .q  (state)
    );

    assign q  = state;
    assign qb = ~state;

endmodule

// File: tb/tb_jk_using_d.sv
// Self-checking bench for jk_using_d: one default-width instance and one
// WIDTH=4 instance, checked against a truth-table model through a scoreboard.
module tb_jk_using_d;
    import ff_pkg::*;

    logic       clk;
    logic       rst;
    logic       j1, k1;
    logic       q1, qb1;
    logic [3:0] j4, k4;
    logic [3:0] q4, qb4;

    logic [4:0] exp_q[$];
    logic       m1;
    logic [3:0] m4;
    int         checks;
    int         errors;

    jk_using_d u_dut1 (
        .j  (j1),
        .k  (k1),
        .clk(clk),
        .rst(rst),
        .q  (q1),
        .qb (qb1)
    );

    jk_using_d #(
        .WIDTH(4)
    ) u_dut4 (
        .j  (j4),
        .k  (k4),
        .clk(clk),
        .rst(rst),
        .q  (q4),
        .qb (qb4)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Truth-table model of one JK bit.
    function automatic logic jk_model(input logic j, input logic k, input logic q);
        logic r;
        case ({j, k})
            HOLD:    r = q;
            RST:     r = 1'b0;
            SET:     r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b", tag, act, exp);
        end
    endtask

    // Drive one edge's worth of inputs, predict, then compare after the edge.
    task automatic drive(input string tag, input logic r,
                         input logic a1, input logic b1,
                         input logic [3:0] a4, input logic [3:0] b4);
        logic [4:0] e;
        @(negedge clk);
        rst = r;
        j1  = a1;
        k1  = b1;
        j4  = a4;
        k4  = b4;
        if (r) begin
            m1 = RST_Q;
            m4 = {4{RST_Q}};
        end else begin
            m1 = jk_model(a1, b1, m1);
            for (int i = 0; i < 4; i++) m4[i] = jk_model(a4[i], b4[i], m4[i]);
        end
        exp_q.push_back({m4, m1});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_q"}, {q4, q1}, e);
        check({tag, "_qb"}, {qb4, qb1}, ~e);
    endtask

    // Same command on both instances (all four wide bits follow the 1-bit one).
    task automatic drive_cmd(input string tag, input logic r, input logic [1:0] cmd);
        drive(tag, r, cmd[1], cmd[0], {4{cmd[1]}}, {4{cmd[0]}});
    endtask

    initial begin
        logic [1:0] c;
        checks = 0;
        errors = 0;
        m1 = 1'bx;
        m4 = 'x;
        rst = 1'b0;
        j1 = 1'b0; k1 = 1'b0;
        j4 = '0;   k4 = '0;

        // Reset for two edges with arbitrary j/k.
        for (int i = 0; i < 2; i++) begin
            drive("reset", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        check("reset_explicit", {q4, q1}, 5'b00000);

        // Hold from 0.
        for (int i = 0; i < 3; i++) drive_cmd("hold0", 1'b0, HOLD);
        // Set, then hold from 1.
        drive_cmd("set", 1'b0, SET);
        for (int i = 0; i < 3; i++) drive_cmd("hold1", 1'b0, HOLD);
        check("hold1_explicit", {q4, q1}, 5'b11111);

        // From q=0: reset command, then set command.
        drive_cmd("rst_edge", 1'b1, HOLD);
        drive_cmd("jk_rst", 1'b0, RST);
        drive_cmd("jk_set", 1'b0, SET);
        check("set_qb_explicit", {qb4, qb1}, 5'b00000);

        // Toggle four times from q=1: 0,1,0,1.
        for (int i = 0; i < 4; i++) drive_cmd("toggle", 1'b0, TOG);
        check("toggle_end_explicit", {q4, q1}, 5'b11111);

        // Reset priority mid-toggle, then release and keep toggling.
        drive_cmd("rst_prio", 1'b1, TOG);
        drive_cmd("rst_release", 1'b0, TOG);
        check("release_explicit", {q4, q1}, 5'b11111);

        // WIDTH=4 independence from q4=0011.
        drive_cmd("w4_clear", 1'b1, HOLD);
        drive("w4_load", 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0000);
        drive("w4_mix", 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0110);
        check("w4_indep_q", {q4, 1'b0}, {4'b1001, 1'b0});
        check("w4_indep_qb", {qb4, 1'b0}, {4'b0110, 1'b0});

        // Random mix, with occasional reset.
        for (int i = 0; i < 60; i++) begin
            c = 2'($urandom_range(0, 3));
            drive("random", ($urandom_range(0, 9) == 0), c[1], c[0],
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
